// File: rtl/bcd_cnt_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_cnt_pkg
// Description : Shared constants and helpers for the BCD counter core:
//               7-segment patterns (active-low form, {g..a}), BCD digit
//               increment/decrement and a BCD validity check.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_cnt_pkg;

  // Segment patterns in active-low form; a 0 bit lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Widest vector bcd_valid can inspect.
  localparam int MAX_DIGITS = 16;

  // Returns {carry, digit+1}; 9 wraps to 0 with carry.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
    if (d >= 4'd9) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  // Returns {borrow, digit-1}; 0 wraps to 9 with borrow.
  function automatic logic [4:0] bcd_digit_dec(input logic [3:0] d);
    if (d == 4'd0) return {1'b1, 4'd9};
    return {1'b0, d - 4'd1};
  endfunction

  // True when every one of the low 'digits' nibbles of vec is 0..9.
  function automatic logic bcd_valid(input logic [4*MAX_DIGITS-1:0] vec, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && vec[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_cnt_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_cnt_prog_if
// Description : Control and status bundle of the BCD counter core. The
//               master side drives mode/modulus/load, the slave side (the
//               counter) returns tick, count, tc, mod_err and segments.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_cnt_prog_if #(
  parameter int DIGITS = 3
);
  logic                  en;
  logic                  up_dn;
  logic [4*DIGITS-1:0]   mod_val;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  tick;
  logic [4*DIGITS-1:0]   cnt_bcd;
  logic                  tc;
  logic                  mod_err;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output en, up_dn, mod_val, load, load_val,
    input  tick, cnt_bcd, tc, mod_err, seg
  );

  modport slave (
    input  en, up_dn, mod_val, load, load_val,
    output tick, cnt_bcd, tc, mod_err, seg
  );
endinterface
`default_nettype wire

// File: rtl/bcd_cnt_prog_seg7_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg7_dec
// Description : One BCD digit to a 7-segment pattern {g..a}. Digits above 9
//               and an asserted blank input both produce all segments off.
//               SEG_ACT_LOW selects common-anode (1) or common-cathode (0).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_dec
  import bcd_cnt_pkg::*;
#(
  parameter int SEG_ACT_LOW = 1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pat_al;

  // Look up the active-low pattern; anything not 0..9 shows blank.
  always_comb begin
    pat_al = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    pat_al = SEG_0;
        4'd1:    pat_al = SEG_1;
        4'd2:    pat_al = SEG_2;
        4'd3:    pat_al = SEG_3;
        4'd4:    pat_al = SEG_4;
        4'd5:    pat_al = SEG_5;
        4'd6:    pat_al = SEG_6;
        4'd7:    pat_al = SEG_7;
        4'd8:    pat_al = SEG_8;
        4'd9:    pat_al = SEG_9;
        default: pat_al = SEG_BLANK;
      endcase
    end
  end

  assign seg = (SEG_ACT_LOW != 0) ? pat_al : ~pat_al;

endmodule
`default_nettype wire

// File: rtl/bcd_cnt_prog.sv
`default_nettype none
// ============================================================================
// Module      : bcd_cnt_prog
// Description : N-digit BCD up/down counter with programmable modulus,
//               synchronous load, on-chip tick divider and registered
//               per-digit 7-segment outputs. Single clock domain; the
//               divider yields a one-clk enable pulse.
//               Build option CNT_LZ_BLANK_EN: blank leading zero digits
//               (digit 0 always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_cnt_prog
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter int DIV_WIDTH   = 26,
  parameter int DIV_MAX     = 49_999_999,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  bcd_cnt_prog_if.slave    bus
);

  localparam int                   C_W        = 4*DIGITS;
  localparam int                   C_SW       = 7*DIGITS;
  localparam int                   C_VW       = 4*MAX_DIGITS;
  localparam logic [DIV_WIDTH-1:0] C_DIV_TERM = DIV_WIDTH'(DIV_MAX);
  localparam logic [C_SW-1:0]      C_SEG_OFF  = (SEG_ACT_LOW != 0) ? {DIGITS{SEG_BLANK}} : '0;

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 tick_q, tick_d;
  logic [C_W-1:0]       cnt_q, cnt_d;
  logic                 tc_q, tc_d;
  logic                 mod_err_q, mod_err_d;
  logic [C_SW-1:0]      seg_q, seg_d;
  logic [DIGITS-1:0]    blank;
  logic                 carry;

  // Free-running divider; tick marks the clk after the terminal value.
  always_comb begin
    if (div_cnt_q == C_DIV_TERM) begin
      div_cnt_d = '0;
      tick_d    = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
      tick_d    = 1'b0;
    end
  end

  // Modulus sanity is re-evaluated every clk.
  always_comb mod_err_d = !bcd_valid(C_VW'(bus.mod_val), DIGITS);

  // Counter next state: load, then mod_err hold, then ticked step, else hold.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    carry = 1'b1;
    if (bus.load) begin
      if (!bcd_valid(C_VW'(bus.load_val), DIGITS) || (bus.load_val > bus.mod_val))
        cnt_d = '0;
      else
        cnt_d = bus.load_val;
    end else if (mod_err_q) begin
      cnt_d = cnt_q;
    end else if (tick_q && bus.en) begin
      if (bus.up_dn) begin
        if (cnt_q >= bus.mod_val) begin
          cnt_d = '0;
          tc_d  = 1'b1;
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (carry) {carry, cnt_d[4*i +: 4]} = bcd_digit_inc(cnt_q[4*i +: 4]);
          end
        end
      end else begin
        if ((cnt_q == '0) || (cnt_q > bus.mod_val)) begin
          cnt_d = bus.mod_val;
          tc_d  = 1'b1;
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (carry) {carry, cnt_d[4*i +: 4]} = bcd_digit_dec(cnt_q[4*i +: 4]);
          end
        end
      end
    end
  end

`ifdef CNT_LZ_BLANK_EN
  logic lz_run;

  // Blank every digit above the most significant non-zero one; digit 0 stays.
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      lz_run   = lz_run & (cnt_q[4*i +: 4] == 4'd0);
      blank[i] = lz_run;
    end
  end
`else
  // All digits shown, leading zeros included.
  always_comb blank = '0;
`endif

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      seg7_dec #(
        .SEG_ACT_LOW (SEG_ACT_LOW)
      ) u_dec (
        .digit (cnt_q[4*g +: 4]),
        .blank (blank[g]),
        .seg   (seg_d[7*g +: 7])
      );
    end
  endgenerate

  // All state, asynchronously cleared to the idle/blank display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      tc_q      <= 1'b0;
      mod_err_q <= 1'b0;
      seg_q     <= C_SEG_OFF;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      tc_q      <= tc_d;
      mod_err_q <= mod_err_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.cnt_bcd = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.mod_err = mod_err_q;
  assign bus.seg     = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_cnt_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_cnt_prog
// Description : Self-checking bench for bcd_cnt_prog (DIGITS=3, DIV_MAX=4,
//               SEG_ACT_LOW=1): load/decode vector table plus directed
//               counting, wrap, mod_err, enable and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_cnt_prog;

  typedef struct {
    logic [11:0] mod_val;
    logic [11:0] load_val;
    logic [11:0] exp_cnt;
    logic [20:0] exp_seg;
    logic [20:0] exp_seg_lz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [11];

  bcd_cnt_prog_if #(.DIGITS(3)) bus ();

  bcd_cnt_prog #(
    .DIGITS      (3),
    .DIV_WIDTH   (8),
    .DIV_MAX     (4),
    .SEG_ACT_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Leaves time at #1 after an edge where tick is high (bounded).
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.tick) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no tick expected one within 12 clk");
    end
  endtask

  // Advances through the next counting edge; returns #1 after it.
  task automatic next_step();
    wait_tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [11:0] v);
    bus.load_val = v;
    bus.load     = 1'b1;
    @(posedge clk); #1;
    bus.load     = 1'b0;
  endtask

  // Steps the counter n times and checks count and tc against the model.
  task automatic run_steps(input int n, input bit up, input int m, inout int v, input string tag);
    bit tcx;
    for (int s = 0; s < n; s++) begin
      tcx = 1'b0;
      if (up) begin
        if (v >= m) begin v = 0; tcx = 1'b1; end
        else v = v + 1;
      end else begin
        if (v == 0 || v > m) begin v = m; tcx = 1'b1; end
        else v = v - 1;
      end
      next_step();
      check($sformatf("%s[%0d] cnt", tag, s), 32'(bus.cnt_bcd), 32'(to_bcd(v)));
      check($sformatf("%s[%0d] tc", tag, s), 32'(bus.tc), 32'(tcx));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int v;
    int n_tick;
    logic [20:0] exp_s;

    vecs[0]  = '{12'h999, 12'h0A5, 12'h000, {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40}};
    vecs[1]  = '{12'h023, 12'h037, 12'h000, {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40}};
    vecs[2]  = '{12'h023, 12'h017, 12'h017, {7'h40, 7'h79, 7'h78}, {7'h7F, 7'h79, 7'h78}};
    vecs[3]  = '{12'h999, 12'h007, 12'h007, {7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h78}};
    vecs[4]  = '{12'h999, 12'h999, 12'h999, {7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10}};
    vecs[5]  = '{12'h999, 12'h258, 12'h258, {7'h24, 7'h12, 7'h00}, {7'h24, 7'h12, 7'h00}};
    vecs[6]  = '{12'h500, 12'h501, 12'h000, {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40}};
    vecs[7]  = '{12'h500, 12'h500, 12'h500, {7'h12, 7'h40, 7'h40}, {7'h12, 7'h40, 7'h40}};
    vecs[8]  = '{12'h999, 12'h1F0, 12'h000, {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40}};
    vecs[9]  = '{12'h999, 12'h306, 12'h306, {7'h30, 7'h40, 7'h02}, {7'h30, 7'h40, 7'h02}};
    vecs[10] = '{12'h999, 12'h040, 12'h040, {7'h40, 7'h19, 7'h40}, {7'h7F, 7'h19, 7'h40}};

    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.up_dn    = 1'b1;
    bus.mod_val  = 12'h999;
    bus.load     = 1'b0;
    bus.load_val = 12'h000;

    // Reset values, then the first tick position after release.
    #12;
    check("rst cnt", 32'(bus.cnt_bcd), 32'h000);
    check("rst tick", 32'(bus.tick), 32'h0);
    check("rst tc", 32'(bus.tc), 32'h0);
    check("rst mod_err", 32'(bus.mod_err), 32'h0);
    check("rst seg", 32'(bus.seg), 32'h1FFFFF);
    #10;
    rst = 1'b1;
    n_tick = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.tick) begin
        n_tick = k;
        break;
      end
    end
    check("first tick clk", 32'(n_tick), 32'd5);
    @(posedge clk); #1;
    check("tick one clk", 32'(bus.tick), 32'h0);

    // Up count 0..49 and wrap to 0.
    bus.mod_val = 12'h049;
    bus.up_dn   = 1'b1;
    bus.en      = 1'b1;
    v = 0;
    run_steps(50, 1'b1, 49, v, "up");

    // Load/decode table.
    bus.en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.mod_val = vecs[i].mod_val;
      do_load(vecs[i].load_val);
      check($sformatf("load[%0d] cnt", i), 32'(bus.cnt_bcd), 32'(vecs[i].exp_cnt));
      check($sformatf("load[%0d] tc", i), 32'(bus.tc), 32'h0);
      @(posedge clk); #1;
      exp_s = vecs[i].exp_seg;
`ifdef CNT_LZ_BLANK_EN
      exp_s = vecs[i].exp_seg_lz;
`endif
      check($sformatf("load[%0d] seg", i), 32'(bus.seg), 32'(exp_s));
    end

    // Down count from 000 with modulus 120, through 100 -> 099.
    bus.mod_val = 12'h120;
    do_load(12'h000);
    bus.up_dn = 1'b0;
    bus.en    = 1'b1;
    v = 0;
    run_steps(22, 1'b0, 120, v, "down");

    // Load beats a coincident tick that would otherwise wrap.
    bus.en = 1'b0;
    do_load(12'h000);
    bus.en = 1'b1;
    wait_tick();
    do_load(12'h017);
    check("load_vs_tick cnt", 32'(bus.cnt_bcd), 32'h017);
    check("load_vs_tick tc", 32'(bus.tc), 32'h0);

    // mod_err freezes the counter; clearing it resumes counting.
    bus.up_dn = 1'b1;
    next_step();
    check("pre_err cnt", 32'(bus.cnt_bcd), 32'h018);
    bus.mod_val = 12'h1F0;
    @(posedge clk); #1;
    check("mod_err set", 32'(bus.mod_err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      next_step();
      check($sformatf("err_hold[%0d] cnt", i), 32'(bus.cnt_bcd), 32'h018);
      check($sformatf("err_hold[%0d] tc", i), 32'(bus.tc), 32'h0);
    end
    bus.mod_val = 12'h099;
    @(posedge clk); #1;
    check("mod_err clr", 32'(bus.mod_err), 32'h0);
    next_step();
    check("resume cnt", 32'(bus.cnt_bcd), 32'h019);

    // Modulus lowered below the count wraps on the next up step.
    bus.en = 1'b0;
    do_load(12'h050);
    check("pre_lower cnt", 32'(bus.cnt_bcd), 32'h050);
    bus.mod_val = 12'h030;
    bus.en      = 1'b1;
    next_step();
    check("lower cnt", 32'(bus.cnt_bcd), 32'h000);
    check("lower tc", 32'(bus.tc), 32'h1);
    @(posedge clk); #1;
    check("tc width", 32'(bus.tc), 32'h0);
    next_step();
    check("after_wrap cnt", 32'(bus.cnt_bcd), 32'h001);
    check("after_wrap tc", 32'(bus.tc), 32'h0);

    // Modulus 0: every step lands on 0 with tc, both directions.
    bus.mod_val = 12'h000;
    next_step();
    check("mod0 up cnt", 32'(bus.cnt_bcd), 32'h000);
    check("mod0 up tc", 32'(bus.tc), 32'h1);
    bus.up_dn = 1'b0;
    next_step();
    check("mod0 dn cnt", 32'(bus.cnt_bcd), 32'h000);
    check("mod0 dn tc", 32'(bus.tc), 32'h1);

    // Direction change applies from the next step.
    bus.en      = 1'b0;
    bus.mod_val = 12'h099;
    do_load(12'h005);
    bus.up_dn = 1'b1;
    bus.en    = 1'b1;
    next_step();
    check("dir up cnt", 32'(bus.cnt_bcd), 32'h006);
    bus.up_dn = 1'b0;
    next_step();
    check("dir dn1 cnt", 32'(bus.cnt_bcd), 32'h005);
    next_step();
    check("dir dn2 cnt", 32'(bus.cnt_bcd), 32'h004);

    // en=0 holds across ticks.
    bus.en = 1'b0;
    do_load(12'h007);
    for (int i = 0; i < 3; i++) begin
      next_step();
      check($sformatf("en_hold[%0d] cnt", i), 32'(bus.cnt_bcd), 32'h007);
      check($sformatf("en_hold[%0d] tc", i), 32'(bus.tc), 32'h0);
    end

    // Asynchronous reset in the middle of a clk period while counting.
    bus.up_dn = 1'b1;
    bus.en    = 1'b1;
    next_step();
    check("pre_rst cnt", 32'(bus.cnt_bcd), 32'h008);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst cnt", 32'(bus.cnt_bcd), 32'h000);
    check("arst tick", 32'(bus.tick), 32'h0);
    check("arst tc", 32'(bus.tc), 32'h0);
    check("arst mod_err", 32'(bus.mod_err), 32'h0);
    check("arst seg", 32'(bus.seg), 32'h1FFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
